button_pio_capture: RTL and testbench



---
 rtl/button_pio_pkg.sv | 18 +
 rtl/button_pio_capture_if.sv | 23 ++
 rtl/button_debounce_ch.sv | 63 ++++++
 rtl/button_pio_capture.sv | 123 ++++++++++++
 tb/tb_button_pio_capture.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/button_pio_pkg.sv
// button_pio_pkg
// Shared constants for the button PIO capture block: Avalon-MM word
// addresses of the four registers and the bit layout of the INFO register.
// No ports; imported by the interface consumers and the top module.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
  localparam logic [1:0] ADDR_INFO         = 2'd3;

  // INFO register layout
  localparam int INFO_NCH_LSB        = 0;
  localparam int INFO_NCH_W          = 6;
  localparam int INFO_ACTIVE_LOW_BIT = 8;
  localparam int INFO_IRQ_BIT        = 9;

endpackage

// File: rtl/button_pio_capture_if.sv
// button_pio_capture_if
// Avalon-MM slave bus of the button PIO block.
//   address   [1:0]  word address
//   read             read strobe
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] read data
// Handshake: no waitrequest. A write is accepted on every clock edge where
// write is high. A read is accepted on every edge where read is high and
// readdata carries the response from the following cycle on (fixed latency
// 1), holding it until the next accepted read.
interface button_pio_capture_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output read, output write,
                  output writedata, input readdata);
  modport slave  (input address, input read, input write,
                  input writedata, output readdata);
endinterface

// File: rtl/button_debounce_ch.sv
// button_debounce_ch
// One input channel: 2-flop synchroniser, polarity normalisation
// (pressed = 1), debounce counter and stable level, plus a one-cycle pulse
// on the edge where the stable level goes from released to pressed.
//   clk, reset  clock, synchronous active-high reset
//   pin_i       raw asynchronous pin
//   level_o     debounced stable level (1 = pressed)
//   rise_o      high in the cycle whose clock edge sets level_o to 1
module button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Normalising before the synchroniser lets its reset value (0) stand for
  // the released level regardless of pin polarity.
  logic pin_norm;
  assign pin_norm = pin_i ^ (ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          differ, toggle;

  always_comb begin
    differ  = (sync2_q != level_q);
    toggle  = differ && (cnt_q == CNT_LAST);
    cnt_d   = '0;
    level_d = level_q;
    if (toggle) begin
      level_d = ~level_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= pin_norm;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  // Combinational so the capture register sets on the same edge as the level.
  assign rise_o  = toggle && !level_q;

endmodule

// File: rtl/button_pio_capture.sv
// button_pio_capture
// N_CH debounced button/switch inputs with edge capture, exposed through an
// Avalon-MM slave (DATA, IRQ_MASK, EDGE_CAPTURE, INFO) and a level interrupt.
//   clk, reset  clock, synchronous active-high reset
//   pins_in     raw asynchronous pins
//   bus         Avalon-MM slave (button_pio_capture_if.slave)
//   irq         registered OR of (capture & mask)
//   led         debounced pressed state, 1 = pressed
// Optional feature: define BUTTON_PIO_IRQ_EN to build the IRQ_MASK register
// and interrupt. Without it irq is 0, IRQ_MASK reads 0 and ignores writes,
// and edge capture remains available for polling.
module button_pio_capture
  import button_pio_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      pins_in,
  button_pio_capture_if.slave  bus,
  output logic                 irq,
  output logic [N_CH-1:0]      led
);

  logic [N_CH-1:0] level, rise;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pin_i   (pins_in[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  logic [N_CH-1:0] capture_q, capture_d, clr;
  logic [31:0]     readdata_q, readdata_d;
  logic [31:0]     data_w, capture_w, mask_w, info_w;

  // A new press in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    clr = '0;
    if (bus.write && bus.address == ADDR_EDGE_CAPTURE) begin
      clr = bus.writedata[N_CH-1:0];
    end
    capture_d = (capture_q & ~clr) | rise;
  end

`ifdef BUTTON_PIO_IRQ_EN
  localparam logic IRQ_PRESENT = 1'b1;
  logic [N_CH-1:0] mask_q;
  logic            irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (bus.write && bus.address == ADDR_IRQ_MASK) begin
        mask_q <= bus.writedata[N_CH-1:0];
      end
      irq_q <= |(capture_q & mask_q);
    end
  end

  always_comb begin
    mask_w = '0;
    mask_w[N_CH-1:0] = mask_q;
  end
  assign irq = irq_q;
`else
  localparam logic IRQ_PRESENT = 1'b0;
  assign mask_w = '0;
  assign irq    = 1'b0;
`endif

  // Zero-extend the per-channel vectors to the 32-bit bus.
  always_comb begin
    data_w    = '0;
    capture_w = '0;
    info_w    = '0;
    data_w[N_CH-1:0]    = level;
    capture_w[N_CH-1:0] = capture_q;
    info_w[INFO_NCH_LSB +: INFO_NCH_W] = INFO_NCH_W'(N_CH);
    info_w[INFO_ACTIVE_LOW_BIT]        = (ACTIVE_LOW != 0);
    info_w[INFO_IRQ_BIT]               = IRQ_PRESENT;
  end

  // Reads sample the current register values, so a simultaneous write is
  // only visible to the next read.
  always_comb begin
    readdata_d = readdata_q;
    if (bus.read) begin
      unique case (bus.address)
        ADDR_DATA:         readdata_d = data_w;
        ADDR_IRQ_MASK:     readdata_d = mask_w;
        ADDR_EDGE_CAPTURE: readdata_d = capture_w;
        ADDR_INFO:         readdata_d = info_w;
        default:           readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q  <= '0;
      readdata_q <= '0;
    end else begin
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign led          = level;

endmodule

// File: tb/tb_button_pio_capture.sv
module tb_button_pio_capture;
  import button_pio_pkg::*;

  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int AL   = 1;

`ifdef BUTTON_PIO_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  localparam logic [31:0] INFO_EXP = 32'h0000_0104 | (32'(IRQ_EN) << 9);

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] pins_in;
  logic            irq;
  logic [N_CH-1:0] led;

  always #5 clk = ~clk;

  button_pio_capture_if bus ();

  button_pio_capture #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pins_in (pins_in),
    .bus     (bus.slave),
    .irq     (irq),
    .led     (led)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= bus.read & ~reset;

  // Read responses: one expected word per accepted read, compared on the
  // negedge after the read edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL readdata: got %h, required no response (queue empty)", bus.readdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.readdata !== e) begin
          errors++;
          $display("FAIL readdata: got %h, required %h", bus.readdata, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_cycle(input logic [1:0] a, input logic rd, input logic wr,
                           input logic [31:0] wd, input logic [31:0] e);
    bus.address   = a;
    bus.read      = rd;
    bus.write     = wr;
    bus.writedata = wd;
    if (rd) exp_q.push_back(e);
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] e);
    bus_cycle(a, 1'b1, 1'b0, 32'h0, e);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    bus_cycle(a, 1'b0, 1'b1, wd, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.address   = '0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    pins_in       = 4'hF;
    reset         = 1'b1;
    tick(3);
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    tick(2);

    rd_reg(ADDR_DATA, 32'h0);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h0);
    rd_reg(ADDR_IRQ_MASK, 32'h0);
    rd_reg(ADDR_INFO, INFO_EXP);

    // Clean press on ch0: level appears 6 edges after the pin change.
    pins_in[0] = 1'b0;
    tick(5);
    check("ch0_led_early", 32'(led), 32'h0);
    tick(1);
    check("ch0_led", 32'(led), 32'h1);
    rd_reg(ADDR_DATA, 32'h1);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h1);
    check("ch0_irq_unmasked", 32'(irq), 32'h0);

    // Bounce on ch1: low 3, high 1, then low held.
    pins_in[1] = 1'b0;
    tick(3);
    pins_in[1] = 1'b1;
    tick(1);
    check("ch1_bounce_led", 32'(led), 32'h1);
    pins_in[1] = 1'b0;
    tick(5);
    check("ch1_led_early", 32'(led), 32'h1);
    tick(1);
    check("ch1_led", 32'(led), 32'h3);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h3);

    // W1C and mask register, including read+write in the same cycle.
    wr_reg(ADDR_EDGE_CAPTURE, 32'h3);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h0);
    wr_reg(ADDR_IRQ_MASK, 32'h4);
    bus_cycle(ADDR_IRQ_MASK, 1'b1, 1'b1, 32'h0, IRQ_EN ? 32'h4 : 32'h0);
    rd_reg(ADDR_IRQ_MASK, 32'h0);
    wr_reg(ADDR_IRQ_MASK, 32'hF);
    rd_reg(ADDR_IRQ_MASK, IRQ_EN ? 32'hF : 32'h0);
    wr_reg(ADDR_IRQ_MASK, 32'h4);
    wr_reg(ADDR_DATA, 32'hF);
    rd_reg(ADDR_DATA, 32'h3);

    // Masked press on ch2 raises irq one edge after capture; W1C drops it.
    pins_in[2] = 1'b0;
    tick(6);
    check("ch2_led", 32'(led), 32'h7);
    check("ch2_irq_same_edge", 32'(irq), 32'h0);
    tick(1);
    check("ch2_irq", 32'(irq), 32'(IRQ_EN));
    wr_reg(ADDR_EDGE_CAPTURE, 32'h4);
    check("irq_after_w1c_edge", 32'(irq), 32'(IRQ_EN));
    tick(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Release of ch0 clears the level but does not capture.
    pins_in[0] = 1'b1;
    tick(6);
    check("ch0_release_led", 32'(led), 32'h6);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h0);

    // W1C of bit 0 on the same edge ch0's press registers: set wins.
    pins_in[0] = 1'b0;
    tick(5);
    wr_reg(ADDR_EDGE_CAPTURE, 32'h1);
    check("collision_led", 32'(led), 32'h7);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h1);
    check("collision_irq", 32'(irq), 32'h0);
    wr_reg(ADDR_EDGE_CAPTURE, 32'hF);
    rd_reg(ADDR_EDGE_CAPTURE, 32'h0);

    // Reset two cycles into ch3's count; held pins re-debounce from zero.
    pins_in[3] = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(2);
    check("midreset_led", 32'(led), 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    reset = 1'b0;
    rd_reg(ADDR_EDGE_CAPTURE, 32'h0);
    rd_reg(ADDR_DATA, 32'h0);
    tick(3);
    check("post_reset_led_early", 32'(led), 32'h0);
    tick(1);
    check("post_reset_led", 32'(led), 32'hF);
    rd_reg(ADDR_DATA, 32'hF);
    rd_reg(ADDR_EDGE_CAPTURE, 32'hF);
    rd_reg(ADDR_IRQ_MASK, 32'h0);
    check("post_reset_irq", 32'(irq), 32'h0);
    rd_reg(ADDR_INFO, INFO_EXP);

    tick(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
